// File: rtl/ctrl_loop_sequencer.sv
// ctrl_loop_sequencer
//   Fixed-rate scheduler for the flight control loop. Once init_done is high,
//   the block waits for each loop tick (period CLK_HZ/LOOP_HZ cycles). On each
//   tick it reads one 12-byte IMU frame, then starts the angle, PID and PWM
//   stages in that order. Faults send it to ERROR, which holds motor_kill high
//   until clear_err.
//
// Optional feature: define CTRL_SEQ_TIMEOUT_EN to build the per-stage watchdog
//   (err_code 1 after TIMEOUT_CYC cycles in READ/ANGLE/PID/PWM). When it is not
//   defined, stages wait indefinitely.
//
// Ports
//   clk, rst_n                 clock (rising edge), async active-low reset
//   init_done                  IMU initialisation complete (level)
//   read_start                 1-cycle pulse: start IMU burst read
//   data_avalid, data[7:0]     IMU byte strobe / byte
//   read_done                  IMU burst finished (pulse)
//   frame[95:0]                captured frame, byte 0 at [95:88]
//   angle_start / angle_done   angle stage handshake
//   pid_start / pid_done       PID stage handshake
//   pwm_busy[3:0]              per-motor PWM busy
//   pwm_oe                     1-cycle pulse: load all four PWM channels
//   motor_kill                 high while in ERROR
//   err_code[1:0]              0 none, 1 timeout, 2 short frame, 3 init lost
//   overrun_cnt[7:0]           missed ticks, saturating
//   clear_err                  pulse: leave ERROR
//   state[2:0]                 current state (debug)
module ctrl_loop_sequencer #(
  parameter int unsigned CLK_HZ      = 50_000_000,
  parameter int unsigned LOOP_HZ     = 500,
  parameter int unsigned TIMEOUT_CYC = 50_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        init_done,
  output logic        read_start,
  input  logic        data_avalid,
  input  logic [7:0]  data,
  input  logic        read_done,
  output logic [95:0] frame,
  output logic        angle_start,
  input  logic        angle_done,
  output logic        pid_start,
  input  logic        pid_done,
  input  logic [3:0]  pwm_busy,
  output logic        pwm_oe,
  output logic        motor_kill,
  output logic [1:0]  err_code,
  output logic [7:0]  overrun_cnt,
  input  logic        clear_err,
  output logic [2:0]  state
);

  localparam int unsigned PERIOD = CLK_HZ / LOOP_HZ;
  localparam int unsigned PW     = (PERIOD > 1) ? $clog2(PERIOD) : 1;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_TICK = 3'd1,
    S_READ      = 3'd2,
    S_ANGLE     = 3'd3,
    S_PID       = 3'd4,
    S_PWM       = 3'd5,
    S_ERROR     = 3'd6
  } state_t;

  state_t        cur_state;
  logic [PW-1:0] period_cnt;
  logic          tick_pend;
  logic          tick;
  logic          running;
  logic          stage_to;
  logic [3:0]    byte_cnt;

  assign state   = cur_state;
  assign running = (cur_state != S_IDLE) && (cur_state != S_ERROR);
  // The tick fires in the cycle where the counter wraps back to 0.
  assign tick    = running && (period_cnt == PW'(PERIOD - 1));

`ifdef CTRL_SEQ_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

  state_t        prev_state;
  logic [TW-1:0] stage_tmr;
  logic          in_stage;

  assign in_stage = cur_state inside {S_READ, S_ANGLE, S_PID, S_PWM};

  // Entry is detected one cycle late (state != prev_state), so the timer
  // reloads to 1 there. It then holds the number of cycles spent in the stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_state <= S_IDLE;
      stage_tmr  <= '0;
    end else begin
      prev_state <= cur_state;
      if (!in_stage)
        stage_tmr <= '0;
      else if (cur_state != prev_state)
        stage_tmr <= TW'(1);
      else if (!stage_to)
        stage_tmr <= stage_tmr + 1'b1;
    end
  end

  assign stage_to = in_stage && (cur_state == prev_state) &&
                    (stage_tmr == TW'(TIMEOUT_CYC - 1));
`else
  assign stage_to = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_state   <= S_IDLE;
      period_cnt  <= '0;
      tick_pend   <= 1'b0;
      byte_cnt    <= '0;
      frame       <= '0;
      read_start  <= 1'b0;
      angle_start <= 1'b0;
      pid_start   <= 1'b0;
      pwm_oe      <= 1'b0;
      motor_kill  <= 1'b0;
      err_code    <= 2'd0;
      overrun_cnt <= '0;
    end else begin
      read_start  <= 1'b0;
      angle_start <= 1'b0;
      pid_start   <= 1'b0;
      pwm_oe      <= 1'b0;

      if (!running || period_cnt == PW'(PERIOD - 1))
        period_cnt <= '0;
      else
        period_cnt <= period_cnt + 1'b1;

      if (running && !init_done) begin
        cur_state  <= S_ERROR;
        err_code   <= 2'd3;
        motor_kill <= 1'b1;
      end else begin
        case (cur_state)
          S_IDLE: begin
            if (init_done)
              cur_state <= S_WAIT_TICK;
          end

          S_WAIT_TICK: begin
            if (tick_pend) begin
              tick_pend  <= 1'b0;
              read_start <= 1'b1;
              byte_cnt   <= '0;
              cur_state  <= S_READ;
            end
          end

          S_READ: begin
            if (data_avalid && byte_cnt < 4'd12) begin
              for (int unsigned i = 0; i < 12; i++)
                if (byte_cnt == 4'(i))
                  frame[95 - 8*i -: 8] <= data;
              byte_cnt <= byte_cnt + 4'd1;
            end
            if (read_done) begin
              if (byte_cnt == 4'd12) begin
                angle_start <= 1'b1;
                cur_state   <= S_ANGLE;
              end else begin
                cur_state  <= S_ERROR;
                err_code   <= 2'd2;
                motor_kill <= 1'b1;
              end
            end else if (stage_to) begin
              cur_state  <= S_ERROR;
              err_code   <= 2'd1;
              motor_kill <= 1'b1;
            end
          end

          S_ANGLE: begin
            if (angle_done) begin
              pid_start <= 1'b1;
              cur_state <= S_PID;
            end else if (stage_to) begin
              cur_state  <= S_ERROR;
              err_code   <= 2'd1;
              motor_kill <= 1'b1;
            end
          end

          S_PID: begin
            // With PWM idle, pwm_oe is issued on the way into PWM so that it
            // lands one cycle after pid_done. PWM then just exits.
            if (pid_done) begin
              pwm_oe    <= (pwm_busy == 4'b0000);
              cur_state <= S_PWM;
            end else if (stage_to) begin
              cur_state  <= S_ERROR;
              err_code   <= 2'd1;
              motor_kill <= 1'b1;
            end
          end

          S_PWM: begin
            if (pwm_oe) begin
              cur_state <= S_WAIT_TICK;
            end else if (pwm_busy == 4'b0000) begin
              pwm_oe    <= 1'b1;
              cur_state <= S_WAIT_TICK;
            end else if (stage_to) begin
              cur_state  <= S_ERROR;
              err_code   <= 2'd1;
              motor_kill <= 1'b1;
            end
          end

          S_ERROR: begin
            if (clear_err) begin
              cur_state  <= S_IDLE;
              err_code   <= 2'd0;
              motor_kill <= 1'b0;
              tick_pend  <= 1'b0;
            end
          end

          default: cur_state <= S_IDLE;
        endcase
      end

      // The counter is held in ERROR, so a tick never coincides with clear_err.
      if (tick) begin
        tick_pend <= 1'b1;
        if ((tick_pend || cur_state != S_WAIT_TICK) && overrun_cnt != 8'hFF)
          overrun_cnt <= overrun_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_ctrl_loop_sequencer.sv
// tb_ctrl_loop_sequencer
//   Directed bench for ctrl_loop_sequencer with P=100, TIMEOUT_CYC=30.
//   Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_ctrl_loop_sequencer;

  localparam int unsigned CLK_HZ      = 1000;
  localparam int unsigned LOOP_HZ     = 10;
  localparam int unsigned TIMEOUT_CYC = 30;
  localparam int unsigned PERIOD      = CLK_HZ / LOOP_HZ;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        init_done;
  logic        read_start;
  logic        data_avalid;
  logic [7:0]  data;
  logic        read_done;
  logic [95:0] frame;
  logic        angle_start;
  logic        angle_done;
  logic        pid_start;
  logic        pid_done;
  logic [3:0]  pwm_busy;
  logic        pwm_oe;
  logic        motor_kill;
  logic [1:0]  err_code;
  logic [7:0]  overrun_cnt;
  logic        clear_err;
  logic [2:0]  state;

  ctrl_loop_sequencer #(
    .CLK_HZ     (CLK_HZ),
    .LOOP_HZ    (LOOP_HZ),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .init_done  (init_done),
    .read_start (read_start),
    .data_avalid(data_avalid),
    .data       (data),
    .read_done  (read_done),
    .frame      (frame),
    .angle_start(angle_start),
    .angle_done (angle_done),
    .pid_start  (pid_start),
    .pid_done   (pid_done),
    .pwm_busy   (pwm_busy),
    .pwm_oe     (pwm_oe),
    .motor_kill (motor_kill),
    .err_code   (err_code),
    .overrun_cnt(overrun_cnt),
    .clear_err  (clear_err),
    .state      (state)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_checks++;
    if (got === exp)
      n_pass++;
    else
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_pulses"},  96'({read_start, angle_start, pid_start, pwm_oe}), 96'd0);
    check({tag, "_frame"},   frame, 96'd0);
    check({tag, "_kill"},    96'(motor_kill), 96'd0);
    check({tag, "_err"},     96'(err_code), 96'd0);
    check({tag, "_overrun"}, 96'(overrun_cnt), 96'd0);
    check({tag, "_state"},   96'(state), 96'd0);
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    init_done   = 1'b0;
    data_avalid = 1'b0;
    data        = 8'h00;
    read_done   = 1'b0;
    angle_done  = 1'b0;
    pid_done    = 1'b0;
    pwm_busy    = 4'b0000;
    clear_err   = 1'b0;
    step();
    step();
    check_reset_outputs("rst");
    rst_n = 1'b1;
    step();
  endtask

  // Bounded wait for read_start; an expired bound is reported as a failed check.
  task automatic wait_read_start(input string tag, input int unsigned max_cyc,
                                 output int unsigned at_cyc);
    logic found;
    found  = 1'b0;
    at_cyc = 0;
    for (int unsigned i = 0; i < max_cyc && !found; i++) begin
      step();
      if (read_start) begin
        found  = 1'b1;
        at_cyc = cyc;
      end
    end
    check(tag, 96'(found), 96'd1);
  endtask

  task automatic feed_bytes(input logic [7:0] first, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      data_avalid = 1'b1;
      data        = first + 8'(i);
      step();
    end
    data_avalid = 1'b0;
    data        = 8'h00;
  endtask

  task automatic pulse_read_done();
    read_done = 1'b1;
    step();
    read_done = 1'b0;
  endtask

  task automatic pulse_angle_done();
    angle_done = 1'b1;
    step();
    angle_done = 1'b0;
  endtask

  int unsigned r0, r1, k;
  logic        seen;

  initial begin
    do_reset();

    // Nominal loop, with a 13th byte that must be ignored.
    init_done = 1'b1;
    wait_read_start("nom_rs", PERIOD + 10, r0);
    check("nom_read_state", 96'(state), 96'd2);
    data_avalid = 1'b1;
    data        = 8'h01;
    step();
    check("nom_rs_one_cycle", 96'(read_start), 96'd0);
    feed_bytes(8'h02, 11);
    feed_bytes(8'hFF, 1);
    pulse_read_done();
    check("nom_angle_start", 96'({angle_start, state}), 96'({1'b1, 3'd3}));
    check("nom_frame", frame, 96'h0102030405060708090A0B0C);
    step();
    check("nom_angle_one_cycle", 96'(angle_start), 96'd0);
    angle_done = 1'b1;
    step();
    angle_done = 1'b0;
    check("nom_pid_start", 96'({pid_start, state}), 96'({1'b1, 3'd4}));
    pid_done = 1'b1;
    step();
    pid_done = 1'b0;
    check("nom_pwm_oe", 96'({pwm_oe, pid_start}), 96'({1'b1, 1'b0}));
    step();
    check("nom_after_oe", 96'({pwm_oe, state}), 96'({1'b0, 3'd1}));
    wait_read_start("nom_rs2", PERIOD, r1);
    check("nom_period", 96'(r1 - r0), 96'(PERIOD));
    check("nom_overrun", 96'(overrun_cnt), 96'd0);

    // Short frame: 11 bytes only. Byte 11 keeps its previous value.
    feed_bytes(8'hA0, 11);
    pulse_read_done();
    check("short_err", 96'({state, err_code, motor_kill}), 96'({3'd6, 2'd2, 1'b1}));
    check("short_no_angle", 96'(angle_start), 96'd0);
    check("short_frame", frame, 96'hA0A1A2A3A4A5A6A7A8A9AA0C);
    clear_err = 1'b1;
    step();
    clear_err = 1'b0;
    check("short_clear", 96'({state, err_code, motor_kill}), 96'({3'd0, 2'd0, 1'b0}));
    step();
    check("short_resume_state", 96'(state), 96'd1);
    wait_read_start("short_resume_rs", PERIOD + 10, r0);

    // PWM busy: pwm_oe only after busy clears.
    do_reset();
    init_done = 1'b1;
    wait_read_start("busy_rs", PERIOD + 10, r0);
    feed_bytes(8'h10, 12);
    pulse_read_done();
    pulse_angle_done();
    pid_done = 1'b1;
    pwm_busy = 4'b0100;
    step();
    pid_done = 1'b0;
    check("busy_pwm_state", 96'({state, pwm_oe}), 96'({3'd5, 1'b0}));
    seen = 1'b0;
    for (int unsigned i = 0; i < 10; i++) begin
      step();
      seen = seen | pwm_oe;
    end
    check("busy_no_oe", 96'(seen), 96'd0);
    pwm_busy = 4'b0000;
    step();
    check("busy_oe", 96'({pwm_oe, state}), 96'({1'b1, 3'd1}));
    step();
    check("busy_oe_one_cycle", 96'(pwm_oe), 96'd0);

    // Overrun: PID held for 250 cycles spans two ticks.
    do_reset();
    init_done = 1'b1;
    wait_read_start("ovr_rs", PERIOD + 10, r0);
    feed_bytes(8'h20, 12);
    pulse_read_done();
    pulse_angle_done();
`ifdef CTRL_SEQ_TIMEOUT_EN
    k = 0;
    for (int unsigned i = 0; i < 60 && state != 3'd6; i++) begin
      step();
      k++;
    end
    check("pid_to_cycles", 96'(k), 96'(TIMEOUT_CYC));
    check("pid_to_err", 96'({err_code, motor_kill}), 96'({2'd1, 1'b1}));
`else
    for (int unsigned i = 0; i < 250; i++) step();
    check("ovr_still_pid", 96'(state), 96'd4);
    pid_done = 1'b1;
    step();
    pid_done = 1'b0;
    check("ovr_oe", 96'(pwm_oe), 96'd1);
    step();
    check("ovr_wait_tick", 96'(state), 96'd1);
    step();
    check("ovr_rs", 96'({read_start, state}), 96'({1'b1, 3'd2}));
    check("ovr_cnt", 96'(overrun_cnt), 96'd2);
`endif

    // Angle stage watchdog (or indefinite wait when it is not built).
    do_reset();
    init_done = 1'b1;
    wait_read_start("to_rs", PERIOD + 10, r0);
    feed_bytes(8'h30, 12);
    pulse_read_done();
    check("to_angle_start", 96'(angle_start), 96'd1);
`ifdef CTRL_SEQ_TIMEOUT_EN
    k = 0;
    for (int unsigned i = 0; i < 60 && state != 3'd6; i++) begin
      step();
      k++;
    end
    check("to_cycles", 96'(k), 96'(TIMEOUT_CYC));
    check("to_err", 96'({err_code, motor_kill}), 96'({2'd1, 1'b1}));
`else
    for (int unsigned i = 0; i < 26000; i++) step();
    check("hold_angle_state", 96'(state), 96'd3);
    check("hold_overrun_sat", 96'(overrun_cnt), 96'd255);
    check("hold_err", 96'({err_code, motor_kill}), 96'd0);
    pulse_angle_done();
    check("hold_pid_start", 96'(pid_start), 96'd1);
`endif

    // Init loss during READ, then reset during PID.
    do_reset();
    init_done = 1'b1;
    wait_read_start("init_rs", PERIOD + 10, r0);
    feed_bytes(8'h40, 3);
    init_done = 1'b0;
    step();
    check("init_lost", 96'({state, err_code, motor_kill}), 96'({3'd6, 2'd3, 1'b1}));
    clear_err = 1'b1;
    step();
    clear_err = 1'b0;
    step();
    check("init_idle", 96'({state, err_code, motor_kill}), 96'd0);
    init_done = 1'b1;
    wait_read_start("init_rs2", PERIOD + 10, r0);
    feed_bytes(8'h50, 12);
    pulse_read_done();
    pulse_angle_done();
    check("rst_in_pid", 96'(state), 96'd4);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_pid");
    rst_n = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ctrl_loop_sequencer.md
# ctrl_loop_sequencer

Fixed-rate scheduler for the flight control loop. Once the IMU reports initialisation complete, the block issues one IMU burst read per loop period and captures the 12-byte accel/gyro frame. It then starts the angle computation, the PID update and the four-motor PWM load, in that order. It sits between the top-level glue and the IMU, CORDIC, PID and PWM blocks, replacing ad-hoc free-running sequencing with a timed, watchdogged loop.

## Interface
- CLK_HZ, 50000000, system clock frequency
- LOOP_HZ, 500, control loop rate; period P = CLK_HZ/LOOP_HZ cycles (100000 at defaults)
- TIMEOUT_CYC, 50000, max cycles any stage may wait for its done/handshake
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- init_done  in  1  IMU initialisation complete (level)
- read_start  out  1  one-cycle pulse, starts IMU burst read
- data_avalid  in  1  IMU byte strobe
- data  in  8  IMU byte
- read_done  in  1  IMU burst finished (pulse)
- frame  out  96  captured frame; byte 0 at [95:88], byte 11 at [7:0]
- angle_start  out  1  one-cycle pulse
- angle_done  in  1  angle result ready (pulse)
- pid_start  out  1  one-cycle pulse
- pid_done  in  1  PID outputs ready (pulse)
- pwm_busy  in  4  per-motor PWM busy
- pwm_oe  out  1  one-cycle pulse, loads all four PWM channels
- motor_kill  out  1  high in ERROR; forces PWM targets to zero downstream
- err_code  out  2  0 none, 1 stage timeout, 2 short frame, 3 init lost
- overrun_cnt  out  8  missed ticks, saturating
- clear_err  in  1  pulse; leaves ERROR
- state  out  3  current state, for debug

## Operation
- States: IDLE(0), WAIT_TICK(1), READ(2), ANGLE(3), PID(4), PWM(5), ERROR(6).
- IDLE: the period counter is held at 0. When init_done=1, go to WAIT_TICK.
- Period counter: runs 0..P-1 in every state except IDLE and ERROR. A tick fires when the counter wraps to 0. One tick-pending flag holds a tick until it is consumed.
- WAIT_TICK: if a tick is pending, clear it, pulse read_start, clear the byte count and go to READ.
- READ: on each data_avalid with count<12, write data into byte slot[count] and increment count. Bytes beyond 12 are ignored.
  - read_done with count=12 → ANGLE.
  - read_done with count<12 → ERROR, err_code=2.
- ANGLE: pulse angle_start on entry. angle_done → PID.
- PID: pulse pid_start on entry. pid_done → PWM.
- PWM: wait for pwm_busy==4'b0000, pulse pwm_oe, go to WAIT_TICK.
- A tick that arrives while the flag is already set, or arrives in a state other than WAIT_TICK, increments overrun_cnt (saturates at 255). No frame is skipped mid-stage.
- init_done falling in any state except IDLE or ERROR → ERROR, err_code=3.
- ERROR: motor_kill=1 and no pulses are issued.
  - clear_err → IDLE. This clears err_code, the tick flag and the stage timer. overrun_cnt is kept.
- frame only updates on accepted bytes and holds its value otherwise.

## Timing
- Reset values: all pulses 0, frame 0, motor_kill 0, err_code 0, overrun_cnt 0, state IDLE.
- Pulses are exactly one cycle and registered.
- read_start is issued one cycle after WAIT_TICK sees the pending tick.
- angle_start follows read_done by 1 cycle. pid_start follows angle_done by 1 cycle.
- pwm_oe follows pid_done by 1 cycle when pwm_busy=0.
- Stage timer: cleared on every state entry and counts in READ, ANGLE, PID and PWM.
- If the timer reaches TIMEOUT_CYC → ERROR, err_code=1.
- If a done and a timeout occur in the same cycle, the done wins.
- If a tick and a clear_err occur in the same cycle, the tick is dropped.
- Asserting rst_n mid-loop aborts immediately and returns every output to its reset value.

## Configuration
- CTRL_SEQ_TIMEOUT_EN defined: stage timer and err_code=1 behaviour are active as described.
- CTRL_SEQ_TIMEOUT_EN undefined: no stage timer is built, stages wait indefinitely, and err_code=1 never occurs. Short-frame and init-lost errors remain.

## Test plan
- Use small parameters: CLK_HZ=1000, LOOP_HZ=10 (P=100), TIMEOUT_CYC=30.
- Nominal loop: init_done=1, feed 12 bytes 0x01..0x0C then read_done, with angle_done, pid_done and busy=0 prompt → frame=0x0102…0C, single pulses in the order read/angle/pid/pwm, read_start every 100 cycles.
- Short frame: 11 bytes then read_done → state=ERROR, err_code=2, motor_kill=1. clear_err → IDLE, then resumes.
- Timeout: withhold angle_done → ERROR with err_code=1 at 30 cycles after angle_start. With the macro undefined, the block stays in ANGLE indefinitely.
- Overrun: withhold pid_done for 250 cycles, then release → overrun_cnt=2 and the next read_start appears on the next WAIT_TICK visit.
- PWM busy: pwm_busy=4'b0100 for 10 cycles after pid_done → pwm_oe pulses 1 cycle after busy clears, never while busy.
- Reset and init loss: drop init_done during READ → ERROR with err_code=3. Assert rst_n low during PID → every output returns to its reset value.
